// File: rtl/alu_pkg.sv
// Purpose: shared opcode, FSM state and flag definitions for the sequential ALU.
// Ports: none (package).
package alu_pkg;

  // Operation encodings carried on the op input
  typedef enum logic [2:0] {
    OP_NOP     = 3'b000,
    OP_ADD     = 3'b001,
    OP_NAND    = 3'b010,
    OP_COMPARE = 3'b011,
    OP_SHL     = 3'b100,
    OP_SRA     = 3'b101,
    OP_EQUAL   = 3'b110,
    OP_EFFADDR = 3'b111
  } op_t;

  // Control FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  // Result flag bundle
  typedef struct packed {
    logic zero;
    logic slt;
    logic carry;
  } flags_t;

  localparam flags_t FLAGS_CLR = '{zero: 1'b0, slt: 1'b0, carry: 1'b0};

  // True for the two iterative shift opcodes
  function automatic logic is_shift(input op_t op);
    return (op == OP_SHL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_seq_shifter.sv
// Purpose: iterative one-bit-per-cycle shl/sra engine with a down-counter.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   i_load      - capture i_data/i_shamt/i_sra as a new shift job
//   i_data      - value to shift
//   i_shamt     - number of single-bit steps to perform
//   i_sra       - 1: arithmetic right shift, 0: left shift with zero fill
//   i_step      - advance one bit position while steps remain
//   o_next_c    - value after the next step (combinational from registers)
//   o_last_c    - exactly one step remains (combinational from registers)
module alu_seq_shifter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic [WIDTH-1:0]   i_data,
  input  logic [SHAMT_W-1:0] i_shamt,
  input  logic               i_sra,
  input  logic               i_step,
  output logic [WIDTH-1:0]   o_next_c,
  output logic               o_last_c
);

  logic [WIDTH-1:0]   r_value;
  logic [SHAMT_W-1:0] r_count;
  logic               r_sra;

  // Single-bit step: sra replicates the MSB, shl fills zero at the LSB
  assign o_next_c = r_sra ? {r_value[WIDTH-1], r_value[WIDTH-1:1]}
                          : {r_value[WIDTH-2:0], 1'b0};
  assign o_last_c = (r_count == SHAMT_W'(1));

  // Job registers and remaining-step counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_value <= '0;
      r_count <= '0;
      r_sra   <= 1'b0;
    end else if (i_load) begin
      r_value <= i_data;
      r_count <= i_shamt;
      r_sra   <= i_sra;
    end else if (i_step && (r_count != '0)) begin
      r_value <= o_next_c;
      r_count <= r_count - SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/alu_seq_unit.sv
// Purpose: handshaked ALU; single-cycle ops finish in one cycle, shifts iterate
//          one bit per cycle through alu_seq_shifter. All outputs registered.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   in_valid / in_ready - request handshake (in_ready only in IDLE)
//   op, data1, data2    - opcode and operands, captured on acceptance
//   shamt               - shift count for shl/sra
//   out_valid/out_ready - result handshake (out_valid only in DONE)
//   result, zero, slt, carry - result and flags, held while out_valid
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   data1,
  input  logic [WIDTH-1:0]   data2,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               slt,
  output logic               carry
);

  localparam int unsigned SUM_W = WIDTH + 1;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] w_result_d;
  flags_t           r_flags;
  flags_t           w_flags_d;
  op_t              w_op;
  logic             w_accept;
  logic             w_shift_load;
  logic             w_shift_last;
  logic [WIDTH-1:0] w_shift_next;
  logic [SUM_W-1:0] w_sum;

  assign w_op         = op_t'(op);
  assign w_accept     = in_valid && (r_state == ST_IDLE);
  // Zero-length shifts bypass the iterative path
  assign w_shift_load = w_accept && is_shift(w_op) && (shamt != '0);
  assign w_sum        = SUM_W'(data1) + SUM_W'(data2);

  alu_seq_shifter #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_shift_load),
    .i_data   (data1),
    .i_shamt  (shamt),
    .i_sra    (w_op == OP_SRA),
    .i_step   (r_state == ST_SHIFT),
    .o_next_c (w_shift_next),
    .o_last_c (w_shift_last)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next_state = w_shift_load ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        if (w_shift_last) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output next-values: computed at acceptance, or at the final shift step
  always_comb begin
    w_result_d = r_result;
    w_flags_d  = r_flags;
    if (w_accept) begin
      w_result_d = '0;
      w_flags_d  = FLAGS_CLR;
      case (w_op)
        OP_ADD: begin
          w_result_d      = w_sum[WIDTH-1:0];
          w_flags_d.carry = w_sum[WIDTH];
        end
        OP_NAND: begin
          w_result_d = ~(data1 & data2);
        end
        OP_COMPARE: begin
          w_flags_d.slt  = (data1 < data2);
          w_flags_d.zero = (data1 < data2);
        end
        OP_SHL, OP_SRA: begin
          if (shamt == '0) begin
            w_result_d = data1;
          end
        end
        OP_EQUAL: begin
          w_flags_d.zero = (data1 == data2);
        end
        OP_EFFADDR: begin
          // All-ones minus the sum is its bitwise complement
          w_result_d      = ~w_sum[WIDTH-1:0];
          w_flags_d.carry = w_sum[WIDTH];
        end
        default: begin
          w_result_d = '0;
        end
      endcase
    end else if ((r_state == ST_SHIFT) && w_shift_last) begin
      w_result_d = w_shift_next;
    end
  end

  // Output registers; handshake flags track the state being entered
  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= FLAGS_CLR;
    end else begin
      r_in_ready  <= (w_next_state == ST_IDLE);
      r_out_valid <= (w_next_state == ST_DONE);
      r_result    <= w_result_d;
      r_flags     <= w_flags_d;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_flags.zero;
  assign slt       = r_flags.slt;
  assign carry     = r_flags.carry;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Purpose: self-checking bench for alu_seq_unit at WIDTH=8 and WIDTH=16.
module tb_alu_seq_unit;

  logic        clk;
  logic        tb_rst      [2];
  logic        tb_in_valid [2];
  logic        tb_in_ready [2];
  logic [2:0]  tb_op       [2];
  logic [31:0] tb_d1       [2];
  logic [31:0] tb_d2       [2];
  logic [31:0] tb_sh       [2];
  logic        tb_out_valid[2];
  logic        tb_ordy     [2];
  logic [31:0] tb_res      [2];
  logic        tb_z        [2];
  logic        tb_s        [2];
  logic        tb_c        [2];
  logic [7:0]  res8;
  logic [15:0] res16;

  int n_chk = 0;
  int n_err = 0;

  assign tb_res[0] = 32'(res8);
  assign tb_res[1] = 32'(res16);

  alu_seq_unit #(.WIDTH(8), .SHAMT_W(3)) u_dut8 (
    .clk(clk), .reset(tb_rst[0]), .in_valid(tb_in_valid[0]), .in_ready(tb_in_ready[0]),
    .op(tb_op[0]), .data1(tb_d1[0][7:0]), .data2(tb_d2[0][7:0]), .shamt(tb_sh[0][2:0]),
    .out_valid(tb_out_valid[0]), .out_ready(tb_ordy[0]), .result(res8),
    .zero(tb_z[0]), .slt(tb_s[0]), .carry(tb_c[0])
  );

  alu_seq_unit #(.WIDTH(16), .SHAMT_W(4)) u_dut16 (
    .clk(clk), .reset(tb_rst[1]), .in_valid(tb_in_valid[1]), .in_ready(tb_in_ready[1]),
    .op(tb_op[1]), .data1(tb_d1[1][15:0]), .data2(tb_d2[1][15:0]), .shamt(tb_sh[1][3:0]),
    .out_valid(tb_out_valid[1]), .out_ready(tb_ordy[1]), .result(res16),
    .zero(tb_z[1]), .slt(tb_s[1]), .carry(tb_c[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: busy countdown plus the arithmetic answer
  typedef struct {
    bit          known;
    bit          idle;
    bit          valid;
    bit          rsts;
    int unsigned wait_n;
    logic [31:0] res;
    bit          z;
    bit          s;
    bit          c;
  } mdl_t;

  mdl_t m [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m[k].known = 0; m[k].idle = 1; m[k].valid = 0; m[k].rsts = 0;
      m[k].wait_n = 0; m[k].res = '0; m[k].z = 0; m[k].s = 0; m[k].c = 0;
    end
  end

  function automatic int width_of(input int k);
    return (k == 0) ? 8 : 16;
  endfunction

  function automatic mdl_t mdl_accept(input mdl_t mi, input int w, input logic [2:0] o,
                                      input logic [31:0] a_in, input logic [31:0] b_in,
                                      input int unsigned sh);
    mdl_t n;
    longint unsigned mask, a, b, sum;
    longint sa;
    n = mi;
    mask = (64'd1 << w) - 64'd1;
    a = 64'(a_in) & mask;
    b = 64'(b_in) & mask;
    sum = a + b;
    n.res = '0; n.z = 0; n.s = 0; n.c = 0; n.rsts = 0; n.idle = 0; n.wait_n = 0;
    case (o)
      3'd1: begin n.res = 32'(sum & mask); n.c = ((sum >> w) & 64'd1) != 0; end
      3'd2: n.res = 32'(~(a & b) & mask);
      3'd3: begin n.s = (a < b); n.z = (a < b); end
      3'd4: begin n.res = 32'((a << sh) & mask); n.wait_n = sh; end
      3'd5: begin
        sa = (((a >> (w - 1)) & 64'd1) != 0) ? (longint'(a) - longint'(64'd1 << w)) : longint'(a);
        n.res = 32'($unsigned(sa >>> sh) & mask);
        n.wait_n = sh;
      end
      3'd6: n.z = (a == b);
      3'd7: begin n.res = 32'(mask - (sum & mask)); n.c = ((sum >> w) & 64'd1) != 0; end
      default: ;
    endcase
    n.valid = (n.wait_n == 0);
    return n;
  endfunction

  function automatic mdl_t mdl_next(input mdl_t mi, input int w, input bit rst, input bit iv,
                                    input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                    input int unsigned sh, input bit ordy);
    mdl_t n;
    n = mi;
    if (rst) begin
      n.known = 1; n.idle = 1; n.valid = 0; n.rsts = 1; n.wait_n = 0;
      n.res = '0; n.z = 0; n.s = 0; n.c = 0;
    end else if (!mi.known) begin
      n = mi;
    end else if (mi.idle) begin
      if (iv) n = mdl_accept(mi, w, o, a, b, sh);
    end else if (!mi.valid) begin
      n.wait_n = mi.wait_n - 1;
      n.valid = (n.wait_n == 0);
    end else if (ordy) begin
      n.idle = 1;
      n.valid = 0;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      m[k] <= mdl_next(m[k], width_of(k), tb_rst[k], tb_in_valid[k], tb_op[k],
                       tb_d1[k], tb_d2[k], tb_sh[k], tb_ordy[k]);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (m[k].known) begin
        check($sformatf("in_ready[%0d]", k), 32'(tb_in_ready[k]), 32'(m[k].idle));
        check($sformatf("out_valid[%0d]", k), 32'(tb_out_valid[k]), 32'(m[k].valid));
        if (m[k].valid || m[k].rsts) begin
          check($sformatf("result[%0d]", k), tb_res[k], m[k].res);
          check($sformatf("flags[%0d]", k), 32'({tb_z[k], tb_s[k], tb_c[k]}),
                32'({m[k].z, m[k].s, m[k].c}));
        end
      end
    end
  end

  // Issue one request and retire it after 'hold' stalled cycles
  task automatic run_op(input int k, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int unsigned sh, input int hold,
                        output logic [31:0] r, output logic [2:0] f, output int lat);
    int guard;
    guard = 0;
    while (!tb_in_ready[k] && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    if (!tb_in_ready[k]) begin
      n_chk++; n_err++;
      $display("FAIL ready_timeout[%0d]: in_ready stayed 0, required 1", k);
    end
    tb_in_valid[k] = 1'b1; tb_op[k] = o; tb_d1[k] = a; tb_d2[k] = b; tb_sh[k] = sh;
    tb_ordy[k] = 1'b0;
    @(posedge clk); #1;
    // Scramble inputs after acceptance; the in-flight op must ignore them
    tb_in_valid[k] = 1'($urandom_range(0, 1));
    tb_op[k] = 3'($urandom_range(0, 7)); tb_d1[k] = $urandom; tb_d2[k] = $urandom;
    tb_sh[k] = $urandom_range(0, width_of(k) - 1);
    lat = 1;
    while (!tb_out_valid[k] && lat < 40) begin
      @(posedge clk); #1; lat++;
      tb_in_valid[k] = 1'($urandom_range(0, 1));
    end
    if (!tb_out_valid[k]) begin
      n_chk++; n_err++;
      $display("FAIL done_timeout[%0d]: out_valid stayed 0, required 1", k);
    end
    repeat (hold) begin
      @(posedge clk); #1;
      tb_in_valid[k] = 1'($urandom_range(0, 1));
    end
    r = tb_res[k];
    f = {tb_z[k], tb_s[k], tb_c[k]};
    tb_ordy[k] = 1'b1; tb_in_valid[k] = 1'b0;
    @(posedge clk); #1;
    tb_ordy[k] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [2:0]  f;
    int          lat;
    bit          seen;
    int          w;
    for (int k = 0; k < 2; k++) begin
      tb_rst[k] = 1'b1; tb_in_valid[k] = 1'b0; tb_op[k] = '0; tb_d1[k] = '0;
      tb_d2[k] = '0; tb_sh[k] = '0; tb_ordy[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    tb_rst[0] = 1'b0; tb_rst[1] = 1'b0;
    check("rst_in_ready", 32'(tb_in_ready[0]), 32'd1);
    check("rst_out_valid", 32'(tb_out_valid[0]), 32'd0);
    check("rst_result", tb_res[0], 32'd0);

    // Directed WIDTH=8 cases with hand-computed answers
    run_op(0, 3'd1, 32'hF0, 32'h20, 0, 0, r, f, lat);
    check("add_res", r, 32'h10); check("add_flags", 32'(f), 32'b001); check("add_lat", lat, 1);
    run_op(0, 3'd5, 32'h90, 32'h00, 3, 0, r, f, lat);
    check("sra_res", r, 32'hF2); check("sra_lat", lat, 4);
    run_op(0, 3'd4, 32'h81, 32'h00, 1, 0, r, f, lat);
    check("shl_res", r, 32'h02); check("shl_lat", lat, 2);
    run_op(0, 3'd4, 32'hA5, 32'h00, 0, 0, r, f, lat);
    check("shl0_res", r, 32'hA5); check("shl0_lat", lat, 1);
    run_op(0, 3'd3, 32'h05, 32'h07, 0, 0, r, f, lat);
    check("cmp_lt_flags", 32'(f), 32'b110); check("cmp_lt_res", r, 32'h0);
    run_op(0, 3'd3, 32'h07, 32'h05, 0, 0, r, f, lat);
    check("cmp_ge_flags", 32'(f), 32'b000);
    run_op(0, 3'd6, 32'h33, 32'h33, 0, 0, r, f, lat);
    check("eq_flags", 32'(f), 32'b100);
    run_op(0, 3'd2, 32'hF0, 32'h3C, 0, 0, r, f, lat);
    check("nand_res", r, 32'hCF);
    run_op(0, 3'd0, 32'hFF, 32'hFF, 0, 0, r, f, lat);
    check("nop_res", r, 32'h0); check("nop_flags", 32'(f), 32'b000);
    run_op(0, 3'd7, 32'h10, 32'h05, 0, 5, r, f, lat);
    check("effaddr_res_held", r, 32'hEA); check("effaddr_flags", 32'(f), 32'b000);

    // Reset during the second cycle of a long shift discards it
    tb_in_valid[0] = 1'b1; tb_op[0] = 3'd4; tb_d1[0] = 32'h01; tb_sh[0] = 7;
    @(posedge clk); #1;
    tb_in_valid[0] = 1'b0;
    @(posedge clk); #1;
    tb_rst[0] = 1'b1; tb_ordy[0] = 1'b1;
    @(posedge clk); #1;
    tb_rst[0] = 1'b0; tb_ordy[0] = 1'b0;
    check("mid_rst_in_ready", 32'(tb_in_ready[0]), 32'd1);
    check("mid_rst_out_valid", 32'(tb_out_valid[0]), 32'd0);
    check("mid_rst_result", tb_res[0], 32'd0);
    check("mid_rst_flags", 32'({tb_z[0], tb_s[0], tb_c[0]}), 32'd0);
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (tb_out_valid[0]) seen = 1;
    end
    check("no_valid_after_rst", 32'(seen), 32'd0);

    // Directed WIDTH=16 boundaries
    run_op(1, 3'd1, 32'hFFFF, 32'h0001, 0, 0, r, f, lat);
    check("add16_res", r, 32'h0000); check("add16_flags", 32'(f), 32'b001);
    run_op(1, 3'd5, 32'h8000, 32'h0000, 15, 0, r, f, lat);
    check("sra16_res", r, 32'hFFFF); check("sra16_lat", lat, 16);

    // Randomized traffic; correctness judged by the per-cycle model compare
    for (int i = 0; i < 60; i++) begin
      for (int k = 0; k < 2; k++) begin
        logic [31:0] a, b;
        w = width_of(k);
        a = $urandom;
        b = ($urandom_range(0, 3) == 0) ? a : $urandom;
        run_op(k, 3'($urandom_range(0, 7)), a, b, $urandom_range(0, w - 1),
               $urandom_range(0, 3), r, f, lat);
      end
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
